cv_tile_scheduler: RTL and testbench
====================================

// Module: cv_tile_scheduler
// PURPOSE
//  Sequences a bank of CV cores (one wrapper per PE ID) through one conv layer split along output channels.
//  Broadcasts the layer-wide tile geometry once, then for each O-tile: configures the target PE,
//  then pulses load_weight, load_input and store_output, waiting for that PE's idle after each.
//  Sits between the layer controller (start/done) and the shared PE control bus (id/broadcast/cfg/load/store).
// PARAMETERS
//  NUM_PE   4   number of PEs on the bus; tile t is sent to PE (t mod NUM_PE); 1..256
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous active-high reset
//  start         in   1    1-cycle layer start; sampled only in S_IDLE
//  O_total       in   13   total output channels of layer
//  OT            in   13   output-channel tile size
//  I_ext         in   13   input channels per tile (broadcast)
//  H_ext         in   13   tile height (broadcast)
//  W_ext         in   13   tile width (broadcast)
//  pe_idle       in   NUM_PE  idle flags, bit n from PE n
//  busy          out  1    high from cycle after accepted start until done
//  done          out  1    1-cycle pulse, layer finished
//  id            out  8    target PE ID on control bus
//  broadcast     out  1    address all PEs
//  cfg           out  1    config strobe
//  cfg_Iext,cfg_Oext,cfg_Hext,cfg_Wext  out 13 each   config extents
//  cfg_Iori,cfg_Oori,cfg_Hori,cfg_Wori  out 13 each   config origins
//  load_weight, load_input, store_output  out 1 each  1-cycle command pulses
//  tile_idx      out  13   index of tile being processed
// BEHAVIOUR
//  - One clock; reset synchronous active-high. All outputs registered; on rst every output = 0, state = S_IDLE.
//  - HOLD code = 13'h1000 (bits[12:11]==2'b10): PE keeps its current value for that field.
//  - States: S_IDLE -> S_BCAST -> S_CFG -> S_LW -> S_LWW -> S_LI -> S_LIW -> S_SO -> S_SOW -> S_NEXT -> (S_CFG | S_DONE) -> S_IDLE.
//  - S_IDLE: start=1 latches all inputs; if O_total==0 or OT==0 -> S_DONE, else -> S_BCAST. busy=1 from next cycle.
//  - S_BCAST (1 cycle): broadcast=1, cfg=1, Iext=I_ext, Hext=H_ext, Wext=W_ext, Iori=Hori=Wori=0, Oext/Oori=HOLD.
//  - S_CFG (1 cycle): broadcast=0, cfg=1, id=tile_idx mod NUM_PE, Oori=tile_idx*OT, Oext=min(OT, O_total-Oori); other six fields=HOLD.
//  - S_LW/S_LI/S_SO (1 cycle): pulse the matching command with id unchanged.
//  - S_xxW wait states: first cycle is a guard (pe_idle ignored, PE may not yet have dropped idle);
//    thereafter advance on first cycle where pe_idle[id]==1. No timeout; waits indefinitely.
//  - S_NEXT: Oori_next = Oori+OT; if Oori_next >= O_total -> S_DONE else tile_idx++ -> S_CFG.
//  - Oori accumulates in 14 bits internally (no wrap); Oext computed from 13-bit difference, never exceeds OT.
//  - S_DONE: done=1 for exactly 1 cycle, busy=0 that same cycle, -> S_IDLE.
//  - cfg, broadcast, load_*, store_output never high outside their states; at most one of them is high per cycle.
//  - id, cfg_* hold their last values outside cfg cycles (no glitch to 0 between commands).
//  - start while busy ignored (no restart, no queueing). Latched inputs do not follow input changes mid-layer.
//  - rst mid-layer: immediate return to S_IDLE, all outputs 0, no done pulse.
//  - Latency: start at cycle 0 -> broadcast cfg at cycle 1 -> first per-PE cfg at cycle 2 -> load_weight at cycle 3.
// TESTING
//  1 Reset: rst held 2 cycles -> all outputs 0, busy=0; start ignored while rst=1.
//  2 O_total=64, OT=16, NUM_PE=4, pe_idle all 1 -> 1 broadcast cfg then 4 tiles on ids 0,1,2,3;
//    Oori 0,16,32,48; Oext 16; each tile shows LW,LI,SO pulses in order; single done pulse.
//  3 O_total=40, OT=16, NUM_PE=2 -> 3 tiles, ids 0,1,0; Oori 0,16,32; last Oext=8.
//  4 Hold pe_idle[1]=0 for 20 cycles after load_input on tile 1 -> no store_output until 1 cycle after idle returns; other PEs' idle ignored.
//  5 O_total=0 (or OT=0) with start -> no cfg/load/store, done pulse 2 cycles after start; start during busy -> ignored, tile count unchanged.
//  6 rst asserted in S_LIW of tile 2 -> next cycle all outputs 0, busy=0, no done; new start runs full layer correctly from tile 0.

Source files
------------

// File: rtl/cv_tile_scheduler_if.sv
`default_nettype none
// ============================================================================
// cv_tile_scheduler_if : layer-controller + shared PE control bus bundle
// Revision 1.0
// ============================================================================
interface cv_tile_scheduler_if #(
  parameter int NUM_PE = 4
);
  logic              start;
  logic [12:0]       O_total;
  logic [12:0]       OT;
  logic [12:0]       I_ext;
  logic [12:0]       H_ext;
  logic [12:0]       W_ext;
  logic [NUM_PE-1:0] pe_idle;

  logic              busy;
  logic              done;
  logic [7:0]        id;
  logic              broadcast;
  logic              cfg;
  logic [12:0]       cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext;
  logic [12:0]       cfg_Iori, cfg_Oori, cfg_Hori, cfg_Wori;
  logic              load_weight;
  logic              load_input;
  logic              store_output;
  logic [12:0]       tile_idx;

  modport master (
    input  start, O_total, OT, I_ext, H_ext, W_ext, pe_idle,
    output busy, done, id, broadcast, cfg,
    output cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext,
    output cfg_Iori, cfg_Oori, cfg_Hori, cfg_Wori,
    output load_weight, load_input, store_output, tile_idx
  );

  modport slave (
    output start, O_total, OT, I_ext, H_ext, W_ext, pe_idle,
    input  busy, done, id, broadcast, cfg,
    input  cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext,
    input  cfg_Iori, cfg_Oori, cfg_Hori, cfg_Wori,
    input  load_weight, load_input, store_output, tile_idx
  );
endinterface
`default_nettype wire

// File: rtl/cv_tile_scheduler.sv
`default_nettype none
// ============================================================================
// cv_tile_scheduler : walks one conv layer over the PE bank, one O-tile a time
// Revision 1.0
// ============================================================================
module cv_tile_scheduler #(
  parameter int NUM_PE = 4
) (
  input  logic                clk,
  input  logic                rst,
  cv_tile_scheduler_if.master bus
);

  localparam logic [12:0] C_HOLD    = 13'h1000;
  localparam logic [7:0]  C_LAST_ID = 8'(NUM_PE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_BCAST, S_CFG, S_LW, S_LWW, S_LI, S_LIW, S_SO, S_SOW, S_NEXT, S_DONE
  } state_e;

  state_e      state_q;
  logic [12:0] o_total_q, ot_q, tile_idx_q;
  logic [13:0] oori_q;
  logic        guard_q, busy_q, done_q, bcast_q, cfg_q, lw_q, li_q, so_q;
  logic [7:0]  id_q;
  logic [12:0] iext_q, hext_q, wext_q, iori_q, hori_q, wori_q, oext_q, oori_o_q;

  logic [13:0]  oori_d;
  logic [12:0]  orem_d, oext_d, oext0_d;
  logic [255:0] idle_vec;
  logic         idle_sel;

  // Next-tile origin is kept 14 bits wide so the end-of-layer compare cannot wrap.
  always_comb begin
    oori_d   = oori_q + {1'b0, ot_q};
    orem_d   = o_total_q - oori_d[12:0];
    oext_d   = (orem_d < ot_q) ? orem_d : ot_q;
    oext0_d  = (o_total_q < ot_q) ? o_total_q : ot_q;
    idle_vec = 256'(bus.pe_idle);
    idle_sel = idle_vec[id_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      o_total_q  <= '0;
      ot_q       <= '0;
      oori_q     <= '0;
      tile_idx_q <= '0;
      guard_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcast_q    <= 1'b0;
      cfg_q      <= 1'b0;
      lw_q       <= 1'b0;
      li_q       <= 1'b0;
      so_q       <= 1'b0;
      id_q       <= '0;
      iext_q     <= '0;
      hext_q     <= '0;
      wext_q     <= '0;
      iori_q     <= '0;
      hori_q     <= '0;
      wori_q     <= '0;
      oext_q     <= '0;
      oori_o_q   <= '0;
    end else begin
      cfg_q   <= 1'b0;
      bcast_q <= 1'b0;
      lw_q    <= 1'b0;
      li_q    <= 1'b0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            o_total_q  <= bus.O_total;
            ot_q       <= bus.OT;
            oori_q     <= '0;
            tile_idx_q <= '0;
            busy_q     <= 1'b1;
            if ((bus.O_total == '0) || (bus.OT == '0)) begin
              state_q <= S_DONE;
            end else begin
              state_q  <= S_BCAST;
              bcast_q  <= 1'b1;
              cfg_q    <= 1'b1;
              iext_q   <= bus.I_ext;
              hext_q   <= bus.H_ext;
              wext_q   <= bus.W_ext;
              iori_q   <= '0;
              hori_q   <= '0;
              wori_q   <= '0;
              oext_q   <= C_HOLD;
              oori_o_q <= C_HOLD;
            end
          end
        end
        S_BCAST: begin
          state_q  <= S_CFG;
          cfg_q    <= 1'b1;
          id_q     <= '0;
          iext_q   <= C_HOLD;
          hext_q   <= C_HOLD;
          wext_q   <= C_HOLD;
          iori_q   <= C_HOLD;
          hori_q   <= C_HOLD;
          wori_q   <= C_HOLD;
          oext_q   <= oext0_d;
          oori_o_q <= '0;
        end
        S_CFG: begin
          state_q <= S_LW;
          lw_q    <= 1'b1;
        end
        S_LW: begin
          state_q <= S_LWW;
          guard_q <= 1'b1;
        end
        // First wait cycle is a guard: the PE may not have dropped idle yet.
        S_LWW: begin
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (idle_sel) begin
            state_q <= S_LI;
            li_q    <= 1'b1;
          end
        end
        S_LI: begin
          state_q <= S_LIW;
          guard_q <= 1'b1;
        end
        S_LIW: begin
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (idle_sel) begin
            state_q <= S_SO;
            so_q    <= 1'b1;
          end
        end
        S_SO: begin
          state_q <= S_SOW;
          guard_q <= 1'b1;
        end
        S_SOW: begin
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (idle_sel) begin
            state_q <= S_NEXT;
          end
        end
        // The six non-O fields are already HOLD from the first per-PE config.
        S_NEXT: begin
          if (oori_d >= {1'b0, o_total_q}) begin
            state_q <= S_DONE;
          end else begin
            state_q    <= S_CFG;
            cfg_q      <= 1'b1;
            tile_idx_q <= tile_idx_q + 13'd1;
            oori_q     <= oori_d;
            id_q       <= (id_q == C_LAST_ID) ? 8'd0 : id_q + 8'd1;
            oext_q     <= oext_d;
            oori_o_q   <= oori_d[12:0];
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.id           = id_q;
  assign bus.broadcast    = bcast_q;
  assign bus.cfg          = cfg_q;
  assign bus.cfg_Iext     = iext_q;
  assign bus.cfg_Hext     = hext_q;
  assign bus.cfg_Wext     = wext_q;
  assign bus.cfg_Oext     = oext_q;
  assign bus.cfg_Iori     = iori_q;
  assign bus.cfg_Hori     = hori_q;
  assign bus.cfg_Wori     = wori_q;
  assign bus.cfg_Oori     = oori_o_q;
  assign bus.load_weight  = lw_q;
  assign bus.load_input   = li_q;
  assign bus.store_output = so_q;
  assign bus.tile_idx     = tile_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cv_tile_scheduler.sv
`default_nettype none
// ============================================================================
// tb_cv_tile_scheduler : randomized layers checked against an event-list model
// Revision 1.0
// ============================================================================
module tb_cv_tile_scheduler;

  localparam int          NUM_PE = 4;
  localparam int          HSZ    = 4096;
  localparam logic [12:0] C_HOLD = 13'h1000;
  localparam int K_BC = 1, K_CFG = 2, K_LW = 3, K_LI = 4, K_SO = 5, K_DONE = 6;

  typedef logic [135:0] ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  int                cyc = 0;
  int                chk_cnt = 0;
  int                err_cnt = 0;
  bit                idle_rand = 1'b0;
  logic [NUM_PE-1:0] idle_fixed = '1;
  logic [NUM_PE-1:0] hist [HSZ];
  ev_t               got_q [$];
  int                got_cyc [$];
  ev_t               exp_q [$];
  int                lw_cyc = 0;
  int                li_cyc = 0;
  int                start_cyc = 0;

  cv_tile_scheduler_if #(.NUM_PE(NUM_PE)) bus ();

  cv_tile_scheduler #(.NUM_PE(NUM_PE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk(input int kind, input int pid, input int tile,
                             input logic [12:0] ie, he, we, io, ho, wo, oe, oo);
    return ev_t'({4'(kind), 8'(pid), 13'(tile), ie, he, we, io, ho, wo, oe, oo});
  endfunction

  function automatic ev_t all_outs();
    return ev_t'({bus.busy, bus.done, bus.id, bus.broadcast, bus.cfg,
                  bus.cfg_Iext, bus.cfg_Hext, bus.cfg_Wext, bus.cfg_Oext,
                  bus.cfg_Iori, bus.cfg_Hori, bus.cfg_Wori, bus.cfg_Oori,
                  bus.load_weight, bus.load_input, bus.store_output, bus.tile_idx});
  endfunction

  // Command at cycle k after previous command at cycle j: guard cycle j+1 is
  // ignored, then the first cycle with the PE idle must be cycle k-1.
  function automatic bit idle_ok(input int j, input int k, input int p);
    if (k - 1 < j + 2) return 1'b0;
    if (hist[(k - 1) % HSZ][p] !== 1'b1) return 1'b0;
    for (int c = j + 2; c <= k - 2; c++)
      if (hist[c % HSZ][p] !== 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: layer -> ordered list of bus commands.
  task automatic build_exp(input int ott, input int ot, input logic [12:0] ie, he, we);
    exp_q.delete();
    if (ott != 0 && ot != 0) begin
      exp_q.push_back(mk(K_BC, 0, 0, ie, he, we, 13'd0, 13'd0, 13'd0, C_HOLD, C_HOLD));
      for (int t = 0; t * ot < ott; t++) begin
        int oo = t * ot;
        int oe = (ott - oo < ot) ? ott - oo : ot;
        exp_q.push_back(mk(K_CFG, t % NUM_PE, t, C_HOLD, C_HOLD, C_HOLD, C_HOLD, C_HOLD,
                           C_HOLD, 13'(oe), 13'(oo)));
        exp_q.push_back(mk(K_LW, t % NUM_PE, t, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(K_LI, t % NUM_PE, t, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(K_SO, t % NUM_PE, t, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    exp_q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    bus.pe_idle = '1;
    forever begin
      @(posedge clk);
      #1;
      bus.pe_idle = idle_rand ? NUM_PE'($urandom) : idle_fixed;
    end
  end

  initial begin
    int nst;
    int pid;
    forever begin
      @(negedge clk);
      hist[cyc % HSZ] = bus.pe_idle;
      if (!rst) begin
        nst = int'(bus.cfg) + int'(bus.load_weight) + int'(bus.load_input) +
              int'(bus.store_output) + int'(bus.done);
        if (nst != 0 || bus.broadcast) begin
          check("onehot", (nst == 1) && (!bus.broadcast || bus.cfg), 1'b1);
          pid = int'(bus.id);
          if (bus.cfg) begin
            got_q.push_back(mk(bus.broadcast ? K_BC : K_CFG, bus.broadcast ? 0 : pid,
                               int'(bus.tile_idx), bus.cfg_Iext, bus.cfg_Hext, bus.cfg_Wext,
                               bus.cfg_Iori, bus.cfg_Hori, bus.cfg_Wori, bus.cfg_Oext,
                               bus.cfg_Oori));
          end else if (bus.load_weight) begin
            lw_cyc = cyc;
            got_q.push_back(mk(K_LW, pid, int'(bus.tile_idx), 0, 0, 0, 0, 0, 0, 0, 0));
          end else if (bus.load_input) begin
            check($sformatf("li_wait_c%0d", cyc), idle_ok(lw_cyc, cyc, pid), 1'b1);
            li_cyc = cyc;
            got_q.push_back(mk(K_LI, pid, int'(bus.tile_idx), 0, 0, 0, 0, 0, 0, 0, 0));
          end else if (bus.store_output) begin
            check($sformatf("so_wait_c%0d", cyc), idle_ok(li_cyc, cyc, pid), 1'b1);
            got_q.push_back(mk(K_SO, pid, int'(bus.tile_idx), 0, 0, 0, 0, 0, 0, 0, 0));
          end else begin
            check("done_busy", bus.busy, 1'b0);
            got_q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          end
          got_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic start_layer(input int ott, input int ot);
    logic [12:0] ie, he, we;
    ie = 13'($urandom);
    he = 13'($urandom);
    we = 13'($urandom);
    build_exp(ott, ot, ie, he, we);
    @(negedge clk);
    got_q.delete();
    got_cyc.delete();
    bus.start   = 1'b1;
    bus.O_total = 13'(ott);
    bus.OT      = 13'(ot);
    bus.I_ext   = ie;
    bus.H_ext   = he;
    bus.W_ext   = we;
    start_cyc   = cyc;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.O_total = 13'($urandom);
    bus.OT      = 13'($urandom);
    bus.I_ext   = 13'($urandom);
    check("busy_on", bus.busy, 1'b1);
  endtask

  task automatic finish_layer(input bit inject, output int dc);
    bit seen;
    int budget;
    seen   = 1'b0;
    dc     = -1;
    budget = 16 * exp_q.size() + 40;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        dc   = cyc;
      end else if (inject && bus.busy && ($urandom_range(0, 3) == 0)) begin
        bus.start   = 1'b1;
        bus.O_total = 13'($urandom_range(1, 100));
        bus.OT      = 13'($urandom_range(1, 9));
      end
    end
    check("done_seen", seen, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", {bus.done, bus.busy}, 2'b00);
    check("ev_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("ev%0d_c%0d", i, got_cyc[i]), got_q[i], exp_q[i]);
  endtask

  task automatic wait_li(input int tile);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (bus.load_input && bus.tile_idx == 13'(tile)) ok = 1'b1;
    end
    check($sformatf("li_seen_t%0d", tile), ok, 1'b1);
  endtask

  initial begin
    int  dc;
    int  rcyc;
    int  ndone;
    bit  found;
    int  ott;
    int  ot;

    bus.start   = 1'b0;
    bus.O_total = 13'd64;
    bus.OT      = 13'd16;
    bus.I_ext   = '0;
    bus.H_ext   = '0;
    bus.W_ext   = '0;

    // Reset held two cycles with start asserted during it.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_outs", all_outs(), '0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", all_outs(), '0);

    // 64/16 all idle, spurious starts while busy, latency of the first commands.
    start_layer(64, 16);
    finish_layer(1'b1, dc);
    check("lat_bcast", got_cyc.size() > 0 ? got_cyc[0] - start_cyc : -1, 1);
    check("lat_cfg",   got_cyc.size() > 1 ? got_cyc[1] - start_cyc : -1, 2);
    check("lat_lw",    got_cyc.size() > 2 ? got_cyc[2] - start_cyc : -1, 3);

    // Partial last tile.
    start_layer(40, 16);
    finish_layer(1'b0, dc);

    // PE 1 stays busy for 20 cycles after its load_input.
    start_layer(64, 16);
    wait_li(1);
    idle_fixed = 4'b1101;
    repeat (20) @(negedge clk);
    idle_fixed = '1;
    rcyc       = cyc;
    finish_layer(1'b0, dc);
    found = 1'b0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] == mk(K_SO, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        found = 1'b1;
        check("so_after_idle", got_cyc[i] - rcyc, 2);
      end
    end
    check("so_found", found, 1'b1);

    // Empty layers finish two cycles after start.
    start_layer(0, 16);
    finish_layer(1'b1, dc);
    check("zero_ototal_lat", dc - start_cyc, 2);
    start_layer(64, 0);
    finish_layer(1'b0, dc);
    check("zero_ot_lat", dc - start_cyc, 2);

    // Reset while waiting for PE idle after load_input of tile 2.
    start_layer(64, 16);
    wait_li(2);
    idle_fixed = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", all_outs(), '0);
    rst        = 1'b0;
    idle_fixed = '1;
    repeat (6) @(negedge clk);
    ndone = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i][128:125] == 4'(K_DONE)) ndone++;
    check("midrst_no_done", ndone, 0);
    check("midrst_idle", all_outs(), '0);
    start_layer(64, 16);
    finish_layer(1'b0, dc);

    // Randomized layers with random PE idle behaviour.
    idle_rand = 1'b1;
    for (int n = 0; n < 14; n++) begin
      ott = $urandom_range(1, 160);
      ot  = $urandom_range(1, 48);
      case (n)
        3:  ot = 0;
        5:  ott = 0;
        7:  begin ott = 8191; ot = 5000; end
        9:  begin ott = 8191; ot = 4096; end
        11: ot = ott;
        12: ot = ott + $urandom_range(1, 20);
        default: ;
      endcase
      start_layer(ott, ot);
      finish_layer(1'b1, dc);
    end
    idle_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
